// File: rtl/sr_lut_pkg.sv
// Shared types and clamp-range helpers for the SR-LUT requantization datapath.
package sr_lut_pkg;

  typedef enum logic {
    CLAMP_SIGNED   = 1'b0,
    CLAMP_UNSIGNED = 1'b1
  } clamp_mode_e;

  function automatic longint clamp_min(input int unsigned out_w, input clamp_mode_e mode);
    return (mode == CLAMP_UNSIGNED) ? 64'sd0 : -(longint'(1) << (out_w - 1));
  endfunction

  function automatic longint clamp_max(input int unsigned out_w, input clamp_mode_e mode);
    return (mode == CLAMP_UNSIGNED) ? (longint'(1) << out_w) - 1
                                    : (longint'(1) << (out_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantizer: round-half-up arithmetic shift (stage 1) and
// saturating clamp (stage 2). Purely combinational; the top owns the registers.
module requant_lane
  import sr_lut_pkg::*;
#(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned OUT_W   = 6,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic [IN_W-1:0]    x,
  input  logic [SHIFT_W-1:0] shift,
  output logic signed [IN_W:0] r,
  input  logic signed [IN_W:0] r_q,
  input  clamp_mode_e        mode_q,
  output logic [OUT_W-1:0]   y,
  output logic               sat
);

  logic signed [IN_W:0] xe;
  logic signed [IN_W:0] rnd;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] lo;
  logic signed [IN_W:0] hi;

  // One guard bit above IN_W keeps the rounding add from wrapping at the positive limit.
  always_comb begin
    xe  = {x[IN_W-1], x};
    rnd = '0;
    sum = xe;
    r   = xe;
    if (shift != '0) begin
      rnd = (IN_W+1)'(1) << (shift - SHIFT_W'(1));
      sum = xe + rnd;
      r   = sum >>> shift;
    end
  end

  always_comb begin
    lo  = (IN_W+1)'(clamp_min(OUT_W, mode_q));
    hi  = (IN_W+1)'(clamp_max(OUT_W, mode_q));
    y   = r_q[OUT_W-1:0];
    sat = 1'b0;
    if (r_q < lo) begin
      y   = lo[OUT_W-1:0];
      sat = 1'b1;
    end else if (r_q > hi) begin
      y   = hi[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/clamp_requant_pipe.sv
// Multi-lane streaming requantizer: two-stage valid/ready pipeline with
// per-lane saturation flags and a saturating event counter.
module clamp_requant_pipe
  import sr_lut_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned IN_W    = 32,
  parameter int unsigned OUT_W   = 6,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic                   cfg_unsigned,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_count
);

  logic s1_valid, s2_valid;
  logic s1_ready, s2_ready;
  logic signed [IN_W:0] r_d  [LANES];
  logic signed [IN_W:0] s1_r [LANES];
  clamp_mode_e          s1_mode;
  logic [LANES*OUT_W-1:0] y_d;
  logic [LANES-1:0]       sat_d;

  assign s2_ready  = ~s2_valid | out_ready;
  assign s1_ready  = ~s1_valid | s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .x      (in_data[i*IN_W +: IN_W]),
      .shift  (cfg_shift),
      .r      (r_d[i]),
      .r_q    (s1_r[i]),
      .mode_q (s1_mode),
      .y      (y_d[i*OUT_W +: OUT_W]),
      .sat    (sat_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= CLAMP_SIGNED;
      for (int unsigned i = 0; i < LANES; i++) s1_r[i] <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= cfg_unsigned ? CLAMP_UNSIGNED : CLAMP_SIGNED;
        for (int unsigned i = 0; i < LANES; i++) s1_r[i] <= r_d[i];
      end
    end
  end

  // Output register doubles as stage 2; it only loads when empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= y_d;
        out_sat  <= sat_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (s2_valid && out_ready && (|out_sat) && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule
